// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared mode encoding for the arb_mux stream multiplexer
package arb_mux_pkg;
  typedef enum logic {
    ARB_MODE_SELECT = 1'b0,
    ARB_MODE_RR     = 1'b1
  } arb_mode_e;
endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first request at or after ptr_i with wrap.
// A held lock forces the grant onto lock_chan_i regardless of its request.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic             lock_i,
  input  logic [SEL_W-1:0] lock_chan_i,
  output logic [N-1:0]     grant_o
);
  always_comb begin
    int  idx;
    logic found;
    grant_o = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      idx = (idx >= N) ? idx - N : idx;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
    if (lock_i) grant_o = N'(1) << lock_chan_i;
  end
endmodule

// File: rtl/arb_mux.sv
// arb_mux: registered N-channel valid/ready stream mux, SELECT or round-robin arbitration.
// Define ARB_MUX_LOCK_EN to hold round-robin grants for a whole packet (until in_last).
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_chan_q, out_chan_d, rr_ptr_q, rr_ptr_d, lock_chan_q, lock_chan_d;
  logic                locked_q, locked_d;
  logic [CHANNELS-1:0] rr_grant, sel_grant, grant;
  logic [SEL_W-1:0]    g_idx, nxt;
  logic                can_load, accept, rr_mode;

  assign rr_mode   = mode == ARB_MODE_RR;
  assign can_load  = !out_valid_q || out_ready;
  // out-of-range select shifts the one-hot off the top, leaving no grant
  assign sel_grant = (CHANNELS'(1) << select) & in_valid;
  assign grant     = rr_mode ? rr_grant : sel_grant;
  assign in_ready  = grant & {CHANNELS{can_load}};
  assign accept    = |(in_ready & in_valid);

  rr_arbiter #(.N(CHANNELS), .SEL_W(SEL_W)) u_arb (
    .req_i       (in_valid),
    .ptr_i       (rr_ptr_q),
    .lock_i      (locked_q),
    .lock_chan_i (lock_chan_q),
    .grant_o     (rr_grant)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < CHANNELS; i++) if (grant[i]) g_idx = SEL_W'(i);
  end

  always_comb begin
    nxt         = (int'(g_idx) == CHANNELS - 1) ? '0 : g_idx + 1'b1;
    out_valid_d = accept || (out_valid_q && !out_ready);
    out_data_d  = accept ? in_data[g_idx*WIDTH +: WIDTH] : out_data_q;
    out_chan_d  = accept ? g_idx : out_chan_q;
`ifdef ARB_MUX_LOCK_EN
    rr_ptr_d    = (accept && rr_mode && in_last[g_idx]) ? nxt : rr_ptr_q;
    locked_d    = (accept && rr_mode) ? !in_last[g_idx] : locked_q;
    lock_chan_d = (accept && rr_mode) ? g_idx : lock_chan_q;
`else
    rr_ptr_d    = (accept && rr_mode) ? nxt : rr_ptr_q;
    locked_d    = 1'b0;
    lock_chan_d = '0;
`endif
  end

`ifndef ARB_MUX_LOCK_EN
  logic unused_last;
  assign unused_last = ^in_last;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
      locked_q    <= 1'b0;
      lock_chan_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
      locked_q    <= locked_d;
      lock_chan_q <= lock_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
endmodule

// File: doc/arb_mux.md
# arb_mux

Registered N-channel stream multiplexer with valid/ready handshakes, the parametrised successor to the combinational `mux_2`/`mux_4`/`mux_8` tree. It merges `CHANNELS` producer streams into one registered output stream. The channel is chosen either by an explicit `select` input or by round-robin arbitration. It sits between multiple requesters (e.g. fetch/load paths) and a single shared consumer port.

## Interface
- `WIDTH`, 32, data width per channel
- `CHANNELS`, 8, number of input channels, range 2..64; need not be a power of two
- `SEL_W`, `$clog2(CHANNELS)`, select/channel-index width; derived, do not override
---
- `clock`  in  1  rising-edge clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `mode`  in  1  0 = SELECT (`select` picks the channel), 1 = ROUND_ROBIN
- `select`  in  `SEL_W`  channel index used in SELECT mode
- `in_valid`  in  `CHANNELS`  per-channel valid
- `in_data`  in  `CHANNELS*WIDTH`  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_last`  in  `CHANNELS`  per-channel end-of-packet; used only with `ARB_MUX_LOCK_EN`
- `in_ready`  out  `CHANNELS`  per-channel ready; combinational
- `out_valid`  out  1  output holds a beat
- `out_data`  out  `WIDTH`  registered output data
- `out_chan`  out  `SEL_W`  source channel of the current beat
- `out_ready`  in  1  consumer accepts the beat

## Operation
- `can_load = !out_valid || out_ready`.
- The grant vector is one-hot or zero:
  - SELECT mode: `grant[select] = in_valid[select]`. If `select >= CHANNELS`, no grant.
  - ROUND_ROBIN mode: grant the first valid channel at or after `rr_ptr`, scanning upward with wrap.
- `in_ready = grant & {CHANNELS{can_load}}`. At most one bit is set per cycle.
- Accept: the channel g with `in_valid[g] && in_ready[g]`. On the next edge, `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
- Neither an accept nor a consume with `out_valid` high: the output register holds all fields stable.
- Consume (`out_valid && out_ready`) with no simultaneous accept: `out_valid <= 0`. `out_data` and `out_chan` retain their last values.
- Consume and accept in the same cycle: a full-throughput handoff; the new beat is loaded and there is no bubble.
- `rr_ptr` update: on each accept in ROUND_ROBIN mode, `rr_ptr <= (g == CHANNELS-1) ? 0 : g+1`.
  - SELECT-mode accepts leave `rr_ptr` unchanged.
  - Switching `mode` takes effect combinationally the same cycle. `rr_ptr` is preserved across the switch.
- No valid requester: no grant, and all `in_ready` bits are 0.
- Data stability: the block never drops or duplicates a beat. `out_data` does not change while `out_valid && !out_ready`.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready` is held high.
- `in_ready` is combinational from `mode`, `select`, `in_valid`, `out_valid`, `out_ready` and `rr_ptr`. There is no combinational path from `in_data` to any output.
- Reset values: `out_valid = 0`, `out_data = 0`, `out_chan = 0`, `rr_ptr = 0`, lock state cleared.
- Reset asserted mid-stream discards any held beat immediately, without waiting for a clock edge.
- Reset is released synchronously to `clock` externally.

## Configuration
- Macro: `ARB_MUX_LOCK_EN`.
- Defined: packet lock.
  - In ROUND_ROBIN mode, an accept with `in_last[g] = 0` sets `locked = 1` and `lock_chan = g`.
  - While locked, only `lock_chan` can be granted, even if it is not valid; other channels wait.
  - An accept of `lock_chan` with `in_last = 1` clears the lock and advances `rr_ptr` past that channel.
  - `rr_ptr` does not advance on non-last beats.
  - SELECT mode ignores and does not alter the lock.
- Undefined: `in_last` is ignored, there is no lock state, and arbitration runs per beat.

## Structure
- Package `arb_mux_pkg` holds the mode enum `ARB_MODE_SELECT = 1'b0` and `ARB_MODE_RR = 1'b1`.
- Sub-module `rr_arbiter`: combinational grant logic only.
  - Inputs: request vector, pointer, lock controls.
  - Output: one-hot grant.
- `rr_ptr`, the lock state and the output register live in `arb_mux`.
- The data mux is an indexed part-select driven by the encoded grant index.

## Test plan
- **Reset:** assert `reset_n = 0` mid-transfer, with `out_valid = 1` and `out_data = 0xDEADBEEF`. Outputs go to 0 immediately, and `rr_ptr` restarts at 0.
- **SELECT mode:** `mode = 0`, `select = 5`, all channels valid, `in_data[i] = 0x100 + i`. The next cycle shows `out_data = 0x105`, `out_chan = 5`, and `in_ready = 8'b0010_0000`. Setting `select = 9` with `CHANNELS = 10` gives `out_data = 0x109`.
- **Round-robin fairness:** `mode = 1`, all 8 channels valid, `out_ready = 1`. `out_chan` cycles 0,1,…,7,0 with one beat every cycle and no gaps.
- **Sparse requests:** `mode = 1`, only channels 2 and 6 valid, `rr_ptr = 3`. Grants go 6, 2, 6, 2.
- **Backpressure:** `out_ready = 0` for 4 cycles with `out_valid = 1`. `out_data` and `out_chan` are stable and `in_ready = 0`. Releasing `out_ready` gives a back-to-back consume and accept with no bubble.
- **Lock (`ARB_MUX_LOCK_EN`):**
  - Stimulus: channel 1 sends a 3-beat packet (`in_last` on beat 3) while channel 0 is valid throughout, with a 1-cycle gap on channel 1 after beat 1.
  - Required: channel 0 is not granted during the gap, and channel 0 is granted immediately after beat 3.
